// File: rtl/legv8_pkg.sv
// Shared LEGv8 pipeline definitions: datapath widths, fetch FSM encoding and
// a small address helper.
package legv8_pkg;

    localparam int INSTR_W = 32;
    localparam int ADDR_W  = 64;

    typedef enum logic [1:0] {
        ST_PRIME = 2'd0,
        ST_RUN   = 2'd1,
        ST_REDIR = 2'd2,
        ST_HALT  = 2'd3
    } fetch_state_e;

    // Force a byte address onto a word boundary.
    function automatic logic [ADDR_W-1:0] align_word(input logic [ADDR_W-1:0] addr);
        return {addr[ADDR_W-1:2], 2'b00};
    endfunction

endpackage

// File: rtl/if_fetch_ctrl.sv
// Instruction-fetch sequencer: owns the PC, drives the registered instruction
// memory and presents {if_pc, if_instr, if_valid} to the IF/ID register.
module if_fetch_ctrl
    import legv8_pkg::*;
#(
    parameter logic [ADDR_W-1:0] RESET_PC  = 64'h0,
    parameter int unsigned       MEM_BYTES = 256,
    parameter int unsigned       PC_STEP   = 4
) (
    input  logic               clock,
    input  logic               reset_n,
    input  logic               stall,
    input  logic               br_taken,
    input  logic [ADDR_W-1:0]  br_target,
    output logic [ADDR_W-1:0]  imem_addr,
    input  logic [INSTR_W-1:0] imem_data,
    output logic [ADDR_W-1:0]  if_pc,
    output logic [INSTR_W-1:0] if_instr,
    output logic               if_valid,
    output logic               halted,
    output logic               misalign
);

    localparam logic [ADDR_W-1:0] MEM_LIMIT = ADDR_W'(MEM_BYTES);
    localparam logic [ADDR_W-1:0] STEP_INC  = ADDR_W'(PC_STEP);

    logic [ADDR_W-1:0] pc_r;
    logic [ADDR_W-1:0] pc_out_r;
    logic              vld_r;
    logic              halted_r;
    logic              misalign_r;
    fetch_state_e      state_r;
    logic [ADDR_W-1:0] imem_addr_s;

    // Address select: a RUN-state stall re-reads the presented word so if_instr holds.
    always_comb begin
        imem_addr_s = pc_r;
        if (!reset_n) begin
            imem_addr_s = RESET_PC;
        end else if (stall && (state_r == ST_RUN) && !br_taken) begin
            imem_addr_s = pc_out_r;
        end else begin
            imem_addr_s = pc_r;
        end
    end

    // Fetch FSM; a redirect outranks stall and halt in every state but PRIME.
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            pc_r       <= RESET_PC;
            pc_out_r   <= RESET_PC;
            vld_r      <= 1'b0;
            halted_r   <= 1'b0;
            misalign_r <= 1'b0;
            state_r    <= ST_PRIME;
        end else if (br_taken && (state_r != ST_PRIME)) begin
            pc_r       <= align_word(br_target);
            vld_r      <= 1'b0;
            halted_r   <= 1'b0;
            misalign_r <= misalign_r | (|br_target[1:0]);
            state_r    <= ST_REDIR;
        end else begin
            case (state_r)
                ST_PRIME: begin
                    pc_out_r <= pc_r;
                    pc_r     <= pc_r + STEP_INC;
                    vld_r    <= 1'b1;
                    halted_r <= 1'b0;
                    state_r  <= ST_RUN;
                end
                ST_RUN: begin
                    if (stall) begin
                        pc_r     <= pc_r;
                        pc_out_r <= pc_out_r;
                        vld_r    <= vld_r;
                    end else if (pc_r >= MEM_LIMIT) begin
                        vld_r    <= 1'b0;
                        halted_r <= 1'b1;
                        state_r  <= ST_HALT;
                    end else begin
                        pc_out_r <= pc_r;
                        pc_r     <= pc_r + STEP_INC;
                        vld_r    <= 1'b1;
                    end
                end
                ST_REDIR: begin
                    // An out-of-range target never becomes a live word; RUN then halts.
                    pc_out_r <= pc_r;
                    pc_r     <= pc_r + STEP_INC;
                    vld_r    <= (pc_r < MEM_LIMIT);
                    state_r  <= ST_RUN;
                end
                ST_HALT: begin
                    vld_r    <= 1'b0;
                    halted_r <= 1'b1;
                end
                default: begin
                    pc_r     <= RESET_PC;
                    pc_out_r <= RESET_PC;
                    vld_r    <= 1'b0;
                    halted_r <= 1'b0;
                    state_r  <= ST_PRIME;
                end
            endcase
        end
    end

    assign imem_addr = imem_addr_s;
    assign if_pc     = pc_out_r;
    assign if_instr  = imem_data;
    assign if_valid  = vld_r;
    assign halted    = halted_r;
    assign misalign  = misalign_r;

endmodule
